scc_wave_mixer: RTL and testbench

Downstream stage of the 5-channel SCC tone generator. Each time-multiplexed channel slot, it reads the wave RAM at the address the tone generator presents. When that slot's `wave_update` is high, it latches the byte as the channel's current sample. It then scales every channel's current sample by its 4-bit volume, accumulates the five products over one slot frame, and emits one mixed signed sample per frame to the sound output path.

---
 rtl/scc_wave_mixer_pkg.sv | 28 ++
 rtl/scc_wave_mixer_if.sv | 27 ++
 rtl/scc_wave_mixer_mac.sv | 95 +++++++++
 rtl/scc_wave_mixer.sv | 85 ++++++++
 tb/tb_scc_wave_mixer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scc_wave_mixer_pkg.sv
// Shared constants, S1 slot record and table-select helper for the SCC wave mixer.
package scc_wave_mixer_pkg;

    localparam int NUM_CH   = 5;
    localparam int SAMPLE_W = 8;
    localparam int VOL_W    = 4;
    localparam int PROD_W   = 12;
    localparam int ACC_W    = 15;
    localparam int OUT_W    = 11;
    localparam int TBL_W    = 3;
    localparam int WADDR_W  = 5;

    localparam logic [TBL_W-1:0] SLOT_END = 3'd5;

    // Slot captured at S0 and worked on in S1
    typedef struct packed {
        logic             vld;
        logic [TBL_W-1:0] ch;
        logic             upd;
    } s1_slot_t;

    // Channel E borrows channel D's table unless SCC+ mode is on
    function automatic logic [TBL_W-1:0] table_sel(input logic [TBL_W-1:0] slot,
                                                   input logic             scc_plus);
        return (slot == 3'd4 && !scc_plus) ? 3'd3 : slot;
    endfunction

endpackage

// File: rtl/scc_wave_mixer_if.sv
// Slot strobe, wave RAM read port and mixed-sample output of the SCC wave mixer.
interface scc_wave_mixer_if;
    import scc_wave_mixer_pkg::*;

    logic                      enable;
    logic [TBL_W-1:0]          active;
    logic [WADDR_W-1:0]        wave_address;
    logic                      wave_update;
    logic [TBL_W+WADDR_W-1:0]  ram_address;
    logic                      ram_rd;
    logic [SAMPLE_W-1:0]       ram_rdata;
    logic [OUT_W-1:0]          sound_out;
    logic                      sound_valid;

    // System side: tone generator, wave RAM and sound path
    modport master (
        output enable, active, wave_address, wave_update, ram_rdata,
        input  ram_address, ram_rd, sound_out, sound_valid
    );

    // Mixer side
    modport slave (
        input  enable, active, wave_address, wave_update, ram_rdata,
        output ram_address, ram_rd, sound_out, sound_valid
    );

endinterface

// File: rtl/scc_wave_mixer_mac.sv
// S1 volume/mask product and S2 frame accumulate, scale and output.
// Build option: SCC_WAVE_MIXER_SATURATE_EN selects the louder, clamped scaling.
module scc_wave_mixer_mac
    import scc_wave_mixer_pkg::*;
(
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     s1_vld_i,
    input  logic                     s1_end_i,
    input  logic [SAMPLE_W-1:0]      sample_i,
    input  logic [VOL_W-1:0]         volume_i,
    input  logic                     mask_i,
    output logic signed [OUT_W-1:0]  sound_out_o,
    output logic                     sound_valid_o
);

`ifdef SCC_WAVE_MIXER_SATURATE_EN
    function automatic logic signed [OUT_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> 3;
        if (sh > 15'sd1023)
            return 11'sd1023;
        else if (sh < -15'sd1024)
            return 11'h400;
        else
            return OUT_W'(sh);
    endfunction
`else
    // Five full-scale channels fit in 11 bits after the shift, no clipping needed
    function automatic logic signed [OUT_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        return OUT_W'(a >>> 4);
    endfunction
`endif

    logic signed [PROD_W-1:0] prod_full;
    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic                     s2_vld_q, s2_end_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q, acc_sum;
    logic signed [OUT_W-1:0]  out_d;
    logic                     valid_d;

    // Signed 8 x unsigned 4: the true product fits 12 bits, so a 12-bit multiply is exact
    assign prod_full = $signed({{(PROD_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i})
                     * $signed({{(PROD_W-VOL_W){1'b0}}, volume_i});

    // Masked channels and the frame-end slot contribute nothing
    always_comb begin
        prod_d = '0;
        if (s1_vld_i && !s1_end_i && mask_i)
            prod_d = prod_full;
    end

    // S1 -> S2 pipeline register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prod_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_end_q <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            s2_vld_q <= s1_vld_i;
            s2_end_q <= s1_vld_i && s1_end_i;
        end
    end

    assign acc_sum = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // Frame end closes the sum and clears; the next frame's slot 0 lands on the cleared acc
    always_comb begin
        acc_d   = acc_q;
        out_d   = sound_out_o;
        valid_d = 1'b0;
        if (s2_end_q) begin
            out_d   = scale(acc_sum);
            acc_d   = '0;
            valid_d = 1'b1;
        end else if (s2_vld_q) begin
            acc_d = acc_sum;
        end
    end

    // S2 accumulator and output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q         <= '0;
            sound_out_o   <= '0;
            sound_valid_o <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            sound_out_o   <= out_d;
            sound_valid_o <= valid_d;
        end
    end

endmodule

// File: rtl/scc_wave_mixer.sv
// SCC wave mixer top: table select, S0 slot capture, per-channel samples, MAC.
// Build option: SCC_WAVE_MIXER_SATURATE_EN (scaling choice lives in the MAC).
module scc_wave_mixer
    import scc_wave_mixer_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              reg_scc_plus,
    input  logic [VOL_W-1:0]  reg_volume_a,
    input  logic [VOL_W-1:0]  reg_volume_b,
    input  logic [VOL_W-1:0]  reg_volume_c,
    input  logic [VOL_W-1:0]  reg_volume_d,
    input  logic [VOL_W-1:0]  reg_volume_e,
    input  logic [NUM_CH-1:0] reg_channel_mask,
    scc_wave_mixer_if.slave   bus
);

    logic                             slot_rd;
    s1_slot_t                         s1_d, s1_q;
    logic [NUM_CH-1:0][VOL_W-1:0]     volume;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  sample_q;
    logic [SAMPLE_W-1:0]              sample_nx;
    logic [VOL_W-1:0]                 vol_sel;
    logic                             mask_sel;
    logic                             s1_end;

    assign volume = {reg_volume_e, reg_volume_d, reg_volume_c, reg_volume_b, reg_volume_a};

    assign slot_rd         = bus.enable && (bus.active < SLOT_END);
    assign bus.ram_rd      = slot_rd;
    assign bus.ram_address = slot_rd ? {table_sel(bus.active, reg_scc_plus), bus.wave_address} : '0;

    // S0 capture: channel slots and the frame-end slot; idle slots 6-7 dropped
    always_comb begin
        s1_d.vld = bus.enable && (bus.active <= SLOT_END);
        s1_d.ch  = bus.active;
        s1_d.upd = bus.wave_update;
    end

    // S0 register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) s1_q <= '0;
        else         s1_q <= s1_d;
    end

    // Select the S1 channel's next sample (fresh byte on a step, else held), volume and mask
    always_comb begin
        sample_nx = '0;
        vol_sel   = '0;
        mask_sel  = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (s1_q.ch == 3'(n)) begin
                sample_nx = s1_q.upd ? bus.ram_rdata : sample_q[n];
                vol_sel   = volume[n];
                mask_sel  = reg_channel_mask[n];
            end
        end
    end

    // Per-channel sample latch; masked channels keep tracking their waveform
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sample_q <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++)
                if (s1_q.vld && s1_q.upd && s1_q.ch == 3'(n))
                    sample_q[n] <= bus.ram_rdata;
        end
    end

    assign s1_end = (s1_q.ch == SLOT_END);

    scc_wave_mixer_mac u_mac (
        .clk           (clk),
        .nreset        (nreset),
        .s1_vld_i      (s1_q.vld),
        .s1_end_i      (s1_end),
        .sample_i      (sample_nx),
        .volume_i      (vol_sel),
        .mask_i        (mask_sel),
        .sound_out_o   (bus.sound_out),
        .sound_valid_o (bus.sound_valid)
    );

endmodule

// File: tb/tb_scc_wave_mixer.sv
// Directed bench for scc_wave_mixer: frame-level reference model plus literal pins.
module tb_scc_wave_mixer;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       reg_scc_plus;
    logic [3:0] va, vb, vc, vd, ve;
    logic [4:0] mask;

    scc_wave_mixer_if bus();

    scc_wave_mixer dut (
        .clk              (clk),
        .nreset           (nreset),
        .reg_scc_plus     (reg_scc_plus),
        .reg_volume_a     (va),
        .reg_volume_b     (vb),
        .reg_volume_c     (vc),
        .reg_volume_d     (vd),
        .reg_volume_e     (ve),
        .reg_channel_mask (mask),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // Wave RAM: registered read, data valid the clock after the address
    logic [7:0] mem [256];
    always @(posedge clk) bus.ram_rdata <= mem[bus.ram_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int due; int val; } exp_t;
    exp_t expq[$];
    int   msamp[5];
    int   fsum;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int scale_ref(input int s);
`ifdef SCC_WAVE_MIXER_SATURATE_EN
        int t;
        t = s >>> 3;
        if (t > 1023)  t = 1023;
        if (t < -1024) t = -1024;
        return t;
`else
        return s >>> 4;
`endif
    endfunction

    function automatic int vol_of(input int ch);
        case (ch)
            0: return int'(va);
            1: return int'(vb);
            2: return int'(vc);
            3: return int'(vd);
            default: return int'(ve);
        endcase
    endfunction

    function automatic logic [2:0] tsel(input int ch);
        return (ch == 4 && !reg_scc_plus) ? 3'd3 : 3'(ch);
    endfunction

    // One enabled slot; the model follows the frame rules at the moment the slot is issued
    task automatic slot(input int ch, input int addr, input bit upd);
        logic [4:0] a5;
        a5 = 5'(addr);
        bus.enable       = 1'b1;
        bus.active       = 3'(ch);
        bus.wave_address = a5;
        bus.wave_update  = upd;
        if (ch < 5) begin
            if (upd) msamp[ch] = int'($signed(mem[{tsel(ch), a5}]));
            if (mask[ch]) fsum += msamp[ch] * vol_of(ch);
        end else if (ch == 5) begin
            expq.push_back('{due: cyc + 3, val: scale_ref(fsum)});
            fsum = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.enable      = 1'b0;
        bus.active      = 3'd7;
        bus.wave_update = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [4:0] upd, input int addr);
        for (int ch = 0; ch < 5; ch++) slot(ch, addr, upd[ch]);
        slot(5, 0, 1'b0);
    endtask

    // Every output pulse must match the next expected frame, on the right cycle
    always @(negedge clk) begin : cmp
        exp_t e;
        if (nreset && bus.sound_valid) begin
            if (expq.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                check("valid_cycle", cyc, e.due);
                check("sound_out", int'($signed(bus.sound_out)), e.val);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 5; i++) msamp[i] = 0;
        fsum = 0;
        bus.enable = 1'b0; bus.active = 3'd7; bus.wave_address = '0; bus.wave_update = 1'b0;
        reg_scc_plus = 1'b1; mask = 5'b0;
        va = 0; vb = 0; vc = 0; vd = 0; ve = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sound_out", int'(bus.sound_out), 0);
        check("rst_sound_valid", int'(bus.sound_valid), 0);
        check("idle_ram_rd", int'(bus.ram_rd), 0);
        nreset = 1'b1;
        idle(2);

        // Single channel A, full positive, volume 15
        mem[8'h00] = 8'h7F; va = 15; mask = 5'b00001;
        frame(5'b11111, 0);
        idle(4);
`ifdef SCC_WAVE_MIXER_SATURATE_EN
        check("single_lit", int'($signed(bus.sound_out)), 238);
`else
        check("single_lit", int'($signed(bus.sound_out)), 119);
`endif

        // Full-scale, all five channels
        for (int t = 0; t < 5; t++) begin
            mem[{3'(t), 5'd1}] = 8'h7F;
            mem[{3'(t), 5'd2}] = 8'h80;
        end
        va = 15; vb = 15; vc = 15; vd = 15; ve = 15; mask = 5'b11111;
        frame(5'b11111, 1);
        idle(4);
`ifdef SCC_WAVE_MIXER_SATURATE_EN
        check("fullpos_lit", int'($signed(bus.sound_out)), 1023);
`else
        check("fullpos_lit", int'($signed(bus.sound_out)), 595);
`endif
        frame(5'b11111, 2);
        idle(4);
`ifdef SCC_WAVE_MIXER_SATURATE_EN
        check("fullneg_lit", int'($signed(bus.sound_out)), -1024);
`else
        check("fullneg_lit", int'($signed(bus.sound_out)), -600);
`endif

        // Address generation, checked within one cycle so nothing is clocked in
        reg_scc_plus = 1'b0;
        bus.enable = 1'b1; bus.active = 3'd4; bus.wave_address = 5'd5; bus.wave_update = 1'b0;
        #1;
        check("addr_shared", int'(bus.ram_address), 'h65);
        check("rd_shared", int'(bus.ram_rd), 1);
        reg_scc_plus = 1'b1;
        #1;
        check("addr_plus", int'(bus.ram_address), 'h85);
        bus.active = 3'd5;
        #1;
        check("rd_slot5", int'(bus.ram_rd), 0);
        check("addr_slot5", int'(bus.ram_address), 0);
        bus.enable = 1'b0; bus.active = 3'd7;
        idle(1);

        // Shared table: E reads D's table, then its own
        reg_scc_plus = 1'b0;
        mem[{3'd3, 5'd3}] = 8'h20; mem[{3'd4, 5'd3}] = 8'h55;
        mask = 5'b11000; vd = 1; ve = 2;
        frame(5'b11111, 3);
        idle(4);
`ifdef SCC_WAVE_MIXER_SATURATE_EN
        check("shared_lit", int'($signed(bus.sound_out)), 12);
`else
        check("shared_lit", int'($signed(bus.sound_out)), 6);
`endif
        reg_scc_plus = 1'b1;
        frame(5'b10000, 3);
        idle(4);
`ifdef SCC_WAVE_MIXER_SATURATE_EN
        check("plus_lit", int'($signed(bus.sound_out)), 25);
`else
        check("plus_lit", int'($signed(bus.sound_out)), 12);
`endif

        // Update gating: no step, sample held
        mask = 5'b00001; va = 1;
        mem[8'h04] = 8'h40; mem[8'h05] = 8'h10;
        frame(5'b00001, 4);
        idle(4);
`ifdef SCC_WAVE_MIXER_SATURATE_EN
        check("gate_first", int'($signed(bus.sound_out)), 8);
`else
        check("gate_first", int'($signed(bus.sound_out)), 4);
`endif
        frame(5'b00000, 5);
        idle(4);
`ifdef SCC_WAVE_MIXER_SATURATE_EN
        check("gate_held", int'($signed(bus.sound_out)), 8);
`else
        check("gate_held", int'($signed(bus.sound_out)), 4);
`endif

        // Back-to-back frames, enable every clock, mask bit A toggled between frames
        for (int t = 0; t < 5; t++)
            for (int a = 8; a < 14; a++)
                mem[{3'(t), 5'(a)}] = 8'($urandom_range(0, 255));
        va = 7; vb = 3; vc = 15; vd = 9; ve = 1; reg_scc_plus = 1'b1;
        for (int f = 0; f < 6; f++) begin
            mask = (f % 2 == 1) ? 5'b11110 : 5'b11111;
            frame(5'(5'b10101 ^ f), 8 + f);
        end
        idle(4);

        // Missing slots and idle slots inside a frame
        mask = 5'b11111;
        slot(0, 9, 1'b1);
        slot(6, 0, 1'b1);
        slot(2, 9, 1'b1);
        slot(7, 3, 1'b1);
        slot(5, 0, 1'b0);
        idle(4);

        // Mid-frame reset
        for (int t = 0; t < 5; t++) mem[{3'(t), 5'd20}] = 8'(8'h30 + t);
        frame(5'b11111, 20);
        idle(4);
        slot(0, 20, 1'b1);
        slot(1, 20, 1'b1);
        slot(2, 20, 1'b1);
        bus.enable = 1'b0; bus.active = 3'd7;
        #2;
        nreset = 1'b0;
        #1;
        check("midrst_sound_out", int'(bus.sound_out), 0);
        check("midrst_sound_valid", int'(bus.sound_valid), 0);
        for (int i = 0; i < 5; i++) msamp[i] = 0;
        fsum = 0;
        expq.delete();
        @(posedge clk); #1;
        nreset = 1'b1;
        idle(2);
        frame(5'b00000, 20);
        idle(4);
        check("postrst_zero", int'(bus.sound_out), 0);
        frame(5'b00011, 20);
        frame(5'b11100, 20);
        idle(5);

        check("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
